// File: rtl/hilo_mdu.sv
`default_nettype none
// ============================================================================
// Module   : hilo_mdu
// Purpose  : EX-stage HI/LO unit. Executes mult, multu, madd, msub (iterative
//            shift-add, BPC multiplier bits per cycle) and mthi/mtlo (single
//            cycle), owns the architectural HI/LO registers and stalls the
//            pipeline while an iterative operation is in flight.
// Options  : MDU_EARLY_EXIT_EN - leave MUL as soon as the remaining multiplier
//            bits are all zero (same results, shorter latency).
// Revision : 1.0 - initial release
// ============================================================================
module hilo_mdu #(
  parameter int BPC = 1  // multiplier bits retired per cycle: 1, 2 or 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [4:0]  ALUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ReadReq,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done,
  output logic        Stall
);

  localparam int         N        = 32 / BPC;
  localparam logic [5:0] CNT_INIT = 6'(N);

  localparam logic [4:0] OP_MULT  = 5'b00010;
  localparam logic [4:0] OP_MULTU = 5'b11000;
  localparam logic [4:0] OP_MADD  = 5'b01111;
  localparam logic [4:0] OP_MSUB  = 5'b01110;
  localparam logic [4:0] OP_MTHI  = 5'b10010;
  localparam logic [4:0] OP_MTLO  = 5'b10011;

  // How the finished product is folded into {Hi,Lo}
  localparam logic [1:0] KIND_SET = 2'd0;
  localparam logic [1:0] KIND_ADD = 2'd1;
  localparam logic [1:0] KIND_SUB = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] mcand;       // |A|, shifted left BPC bits per iteration
  logic [31:0] mplier;      // |B|, shifted right BPC bits per iteration
  logic [63:0] acc;         // unsigned magnitude product accumulator
  logic [5:0]  cnt;         // iterations remaining
  logic        neg;         // product must be negated in FIX
  logic [1:0]  kind;

  logic        is_signed, is_mul_op, accept, mul_last;
  logic [31:0] mag_a, mag_b, mplier_nxt;
  logic [5:0]  cnt_nxt;
  logic [63:0] pp, prod, hilo_nxt;

  // Operation decode and operand magnitudes (0x80000000 maps to itself, read unsigned)
  always_comb begin
    is_signed = (ALUOp == OP_MULT) || (ALUOp == OP_MADD) || (ALUOp == OP_MSUB);
    is_mul_op = is_signed || (ALUOp == OP_MULTU);
    mag_a     = (is_signed && A[31]) ? (~A + 32'd1) : A;
    mag_b     = (is_signed && B[31]) ? (~B + 32'd1) : B;
    accept    = (state == S_IDLE) && Start && is_mul_op;
  end

  // One shift-add step, exit decision and the FIX-cycle result
  always_comb begin
    pp = '0;
    for (int k = 0; k < BPC; k++) begin
      if (mplier[k]) pp = pp + (mcand << k);
    end
    mplier_nxt = mplier >> BPC;
    cnt_nxt    = cnt - 6'd1;
`ifdef MDU_EARLY_EXIT_EN
    mul_last   = (cnt_nxt == 6'd0) || (mplier_nxt == 32'd0);
`else
    mul_last   = (cnt_nxt == 6'd0);
`endif
    prod = neg ? (~acc + 64'd1) : acc;
    case (kind)
      KIND_ADD: hilo_nxt = {Hi, Lo} + prod;
      KIND_SUB: hilo_nxt = {Hi, Lo} - prod;
      default:  hilo_nxt = prod;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)   state_nxt = S_MUL;
      S_MUL:   if (mul_last) state_nxt = S_FIX;
      S_FIX:                 state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // Status outputs; a request arriving while busy is held upstream
  always_comb begin
    Busy  = (state != S_IDLE);
    Done  = (state == S_FIX);
    Stall = Busy && (Start || ReadReq);
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Iterative multiplier datapath
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      kind   <= KIND_SET;
    end else if (accept) begin
      mcand  <= {32'd0, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      cnt    <= CNT_INIT;
      neg    <= is_signed && (A[31] ^ B[31]);
      kind   <= (ALUOp == OP_MADD) ? KIND_ADD :
                (ALUOp == OP_MSUB) ? KIND_SUB : KIND_SET;
    end else if (state == S_MUL) begin
      acc    <= acc + pp;
      mcand  <= mcand << BPC;
      mplier <= mplier_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Architectural HI/LO: written only in FIX or by mthi/mtlo while idle
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Hi <= '0;
      Lo <= '0;
    end else if (state == S_FIX) begin
      {Hi, Lo} <= hilo_nxt;
    end else if ((state == S_IDLE) && Start) begin
      if (ALUOp == OP_MTHI)      Hi <= A;
      else if (ALUOp == OP_MTLO) Lo <= A;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_mdu
// Purpose  : Self-checking bench for hilo_mdu. The driver updates an
//            arithmetic HI/LO model and queues the expected result of every
//            iterative op; an independent monitor checks it on each Done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_mdu;

  localparam int BPC = 1;
  localparam int N   = 32 / BPC;
`ifdef MDU_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [4:0] OP_MULT  = 5'b00010;
  localparam logic [4:0] OP_MULTU = 5'b11000;
  localparam logic [4:0] OP_MADD  = 5'b01111;
  localparam logic [4:0] OP_MSUB  = 5'b01110;
  localparam logic [4:0] OP_MTHI  = 5'b10010;
  localparam logic [4:0] OP_MTLO  = 5'b10011;

  logic        Clk = 1'b0;
  logic        Reset, Start, ReadReq;
  logic [4:0]  ALUOp;
  logic [31:0] A, B;
  logic [31:0] Hi, Lo;
  logic        Busy, Done, Stall;

  hilo_mdu #(.BPC(BPC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ALUOp(ALUOp), .A(A), .B(B),
    .ReadReq(ReadReq), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] hilo;
    int          busy;
    string       name;
  } exp_t;

  exp_t        scb[$];
  logic [63:0] m_hilo;
  int          checks = 0;
  int          fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: actual=timeout/unexpected required=event", name);
  endtask

  // Full-width product from the arithmetic definition
  function automatic logic [63:0] ref_prod(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sbv;
    longint unsigned ua, ub;
    if (op == OP_MULTU) begin
      ua = 64'(a);
      ub = 64'(b);
      return ua * ub;
    end
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    return sa * sbv;
  endfunction

  // Cycles with Busy high: MUL cycles plus the FIX cycle
  function automatic int exp_busy(input logic [4:0] op, input logic [31:0] b);
    logic [31:0] m;
    int          bl, c;
    m  = (op != OP_MULTU && b[31]) ? (~b + 32'd1) : b;
    bl = 0;
    for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
    c = (bl + BPC - 1) / BPC;
    if (c < 1) c = 1;
    return EARLY ? (c + 1) : (N + 1);
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge Clk);
    while (Busy) begin
      n++;
      if (n > 200) begin
        fail_now("wait_idle");
        return;
      end
      @(negedge Clk);
    end
  endtask

  // Present one instruction from an idle cycle; it is accepted at the next edge
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    logic [63:0] p;
    bit          mul_op;
    wait_idle();
    #1;
    Start = 1'b1; ALUOp = op; A = a; B = b;
    mul_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
    if (mul_op) begin
      p = ref_prod(op, a, b);
      if (op == OP_MADD)      m_hilo = m_hilo + p;
      else if (op == OP_MSUB) m_hilo = m_hilo - p;
      else                    m_hilo = p;
      scb.push_back('{hilo: m_hilo, busy: exp_busy(op, b), name: name});
    end else if (op == OP_MTHI) begin
      m_hilo[63:32] = a;
    end else if (op == OP_MTLO) begin
      m_hilo[31:0] = a;
    end
    @(posedge Clk);
    #1;
    Start = 1'b0;
    if (!mul_op) begin
      @(negedge Clk);
      chk({name, "_hilo"}, {Hi, Lo}, m_hilo);
      chk({name, "_idle"}, Busy, 1'b0);
    end
  endtask

  // Monitor: pops the scoreboard on every Done pulse, checks one cycle later
  initial begin : monitor
    int   bcnt;
    int   blen;
    bit   pend;
    exp_t e;
    bcnt = 0; blen = 0; pend = 1'b0;
    forever begin
      @(negedge Clk);
      if (pend) begin
        pend = 1'b0;
        if (scb.size() == 0) begin
          fail_now("done_without_request");
        end else begin
          e = scb.pop_front();
          chk({e.name, "_hilo"}, {Hi, Lo}, e.hilo);
          chk({e.name, "_busy_cycles"}, 64'(blen), 64'(e.busy));
          chk({e.name, "_busy_fall"}, Busy, 1'b0);
        end
      end
      if (Busy) bcnt++;
      else      bcnt = 0;
      if (Done) begin
        blen = bcnt;
        pend = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: actual=time limit required=finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [63:0] old;
    logic [4:0]  op;
    logic [31:0] ra, rb;
    int          n, sel;
    logic [4:0]  bad_ops [4];
    bad_ops[0] = 5'b00000; bad_ops[1] = 5'b00001;
    bad_ops[2] = 5'b11111; bad_ops[3] = 5'b10000;

    Reset = 1'b1; Start = 1'b0; ReadReq = 1'b0; ALUOp = '0; A = '0; B = '0;
    m_hilo = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_hi", Hi, 32'h0);
    chk("rst_lo", Lo, 32'h0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);

    // Directed arithmetic cases
    issue(OP_MULT, 32'd7, 32'hFFFFFFFD, "mult_7_m3");
    wait_idle();
    chk("plan1_hi", Hi, 32'hFFFFFFFF);
    chk("plan1_lo", Lo, 32'hFFFFFFEB);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    wait_idle();
    chk("plan2u", {Hi, Lo}, 64'hFFFFFFFE_00000001);
    issue(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, "mult_m1_m1");
    wait_idle();
    chk("plan2s", {Hi, Lo}, 64'h1);
    issue(OP_MTHI, 32'h1, 32'h0, "mthi");
    issue(OP_MTLO, 32'h0, 32'h0, "mtlo");
    issue(OP_MADD, 32'h80000000, 32'd2, "madd_min");
    issue(OP_MSUB, 32'd1, 32'd1, "msub_1");
    wait_idle();
    chk("plan3", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFFF);
    issue(OP_MULT, 32'h80000000, 32'h80000000, "mult_min_min");
    issue(OP_MULT, 32'd5, 32'd3, "mult_5_3");
    issue(OP_MULT, 32'd9, 32'd0, "mult_b0");
    issue(OP_MULTU, 32'd1, 32'h80000000, "multu_msb");

    // Stall: read and mtlo held while busy; Hi/Lo frozen until FIX
    wait_idle();
    old = m_hilo;
    issue(OP_MULT, 32'h00001234, 32'hFFFF0001, "mult_stall");
    Start = 1'b1; ALUOp = OP_MTLO; A = 32'h55; ReadReq = 1'b1;
    n = 0;
    forever begin
      @(negedge Clk);
      if (!Busy) break;
      chk("stall_busy", Stall, 1'b1);
      chk("hilo_frozen", {Hi, Lo}, old);
      n++;
      if (n > 200) begin
        fail_now("stall_wait");
        break;
      end
    end
    chk("stall_idle", Stall, 1'b0);
    @(posedge Clk);
    #1 Start = 1'b0; ReadReq = 1'b0;
    m_hilo[31:0] = 32'h55;
    @(negedge Clk);
    chk("mtlo_after_stall", {Hi, Lo}, m_hilo);

    // Reset in the middle of MUL aborts the operation
    issue(OP_MULT, 32'h12345678, 32'h7FFFFFFF, "mult_aborted");
    repeat ((N >= 10) ? 9 : N / 2) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    scb.delete();
    m_hilo = '0;
    @(negedge Clk);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    chk("abort_hilo", {Hi, Lo}, 64'h0);
    issue(OP_MULT, 32'd3, 32'd4, "mult_3_4");
    wait_idle();
    chk("after_abort_lo", Lo, 32'd12);

    // Randomized mix, including ignored op codes and back-to-back issue
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1:    op = OP_MULT;
        2:       op = OP_MULTU;
        3:       op = OP_MADD;
        4:       op = OP_MSUB;
        5:       op = OP_MTHI;
        6:       op = OP_MTLO;
        default: op = bad_ops[$urandom_range(0, 3)];
      endcase
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = $urandom_range(0, 255);
        2:       rb = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'h80000000;
        default: rb = -$urandom_range(1, 1000);
      endcase
      issue(op, ra, rb, $sformatf("rnd%0d", i));
    end

    wait_idle();
    repeat (2) @(negedge Clk);
    chk("scoreboard_drained", 64'(scb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
Multi-cycle multiply/divide-style HI/LO unit in the EX stage, directly downstream of the instruction decoder.
- Consumes the decoded ALUOp and Hi_write/Lo_write intent together with the two register operands.
- Executes mult, multu, madd, msub, mthi and mtlo, and owns the architectural HI and LO registers.
- Drives a Stall back to the pipeline so an instruction touching HI/LO never sees a partial result.

Parameters:
BPC, 1, multiplier bits retired per cycle; legal values 1, 2, 4. N = 32/BPC iteration cycles.

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  synchronous, active-high
Start  input  1  EX-stage instruction is a HI/LO writer (decoder Hi_write|Lo_write)
ALUOp  input  5  decoded operation code
A  input  32  rs operand
B  input  32  rt operand
ReadReq  input  1  EX-stage instruction is mfhi/mflo
Hi  output  32  architectural HI
Lo  output  32  architectural LO
Busy  output  1  iterative operation in flight
Done  output  1  one-cycle pulse, final (FIX) cycle of an iterative operation
Stall  output  1  combinational: Busy & (Start | ReadReq)

Behaviour:
Op codes:
- 00010 mult (signed)
- 11000 multu
- 01111 madd (signed)
- 01110 msub (signed)
- 10010 mthi
- 10011 mtlo
- Start with any other ALUOp is ignored; no state change.

Reset:
- State = IDLE; Hi, Lo, Busy, Done = 0; internal product/counter cleared.
- Reset mid-operation aborts it; the partial result is discarded.

States: IDLE, MUL, FIX.
- IDLE, Start & multiply-class op:
  - Latch |A|, |B| (raw values for multu), result sign = A[31]^B[31] (0 for multu), op kind.
  - Clear 64-bit accumulator; counter = N.
  - Go to MUL. Busy = 1 from the next cycle.
- IDLE, Start & mthi: Hi <= A at the same edge. Mtlo: Lo <= A. Stay IDLE, Busy stays 0, no Done.
- MUL:
  - Each cycle, add (multiplicand << k) for each of the BPC low multiplier bits; shift the multiplier right by BPC; decrement the counter.
  - Exit to FIX when the counter reaches 0.
- FIX:
  - Done = 1. Negate the product if the sign is set, giving a 64-bit signed P.
  - {Hi,Lo} <= P (mult/multu), {Hi,Lo}+P (madd) or {Hi,Lo}-P (msub), mod 2^64.
  - Go to IDLE. Busy = 0 in the following cycle.
- Latency: accept edge E0; Hi/Lo are updated at edge E(N+1). With BPC=1 the new value is visible 33 cycles after accept.

Handshake:
- Start or ReadReq while Busy raises Stall. The upstream stage holds the instruction, and the request is not accepted until Busy falls.
- Start in the cycle after FIX is accepted normally (back-to-back operation).
- Start and ReadReq together while IDLE: the write is accepted. ReadReq observes the pre-edge Hi/Lo (no write-through).
- Hi/Lo are never modified during MUL; reads see the old value until the FIX edge.

Arithmetic:
- Signed magnitude of 0x80000000 is 0x80000000, treated as unsigned 32-bit, so -2^31 * -2^31 = 0x4000000000000000 is correct.
- All accumulator arithmetic is 64-bit, wrap-around, no overflow flag.

Optional Feature:
MDU_EARLY_EXIT_EN
- Defined: in MUL, if the remaining unshifted multiplier is zero, go to FIX at the next edge. Latency = ceil(bitlength(|B|)/BPC)+1. B = 0 goes IDLE -> MUL -> FIX with a single MUL cycle.
- Undefined: always exactly N MUL cycles.
- Results are identical either way.

Test Plan:
1. BPC=1; mult A=7, B=-3 -> Busy for 33 cycles, Done pulses once, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
2. multu A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; then mult with the same operands -> Hi=0, Lo=1.
3. mthi 0x1, mtlo 0x0, then madd A=0x80000000, B=2 -> Hi=0x0, Lo=0x0; then msub A=1, B=1 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFF.
4. Issue mult, then hold ReadReq=1 and a second Start (mtlo 0x55) during MUL -> Stall=1 every busy cycle, Hi/Lo unchanged until FIX; mtlo applies the cycle after Busy falls, Lo=0x55.
5. Assert Reset on the 10th MUL cycle -> next cycle Busy=0, Done=0, Hi=Lo=0, state IDLE; a fresh mult 3*4 gives Lo=12.
6. MDU_EARLY_EXIT_EN defined, BPC=1, mult A=5, B=3 -> Done asserted 3 cycles after accept (2 MUL cycles + FIX), Lo=15; undefined -> Done after 33 cycles, Lo=15.
